// File: rtl/tx_resp_arbiter.sv
// rtl/tx_resp_arbiter.sv - round-robin arbiter feeding RF bytes and serialised ALU words into the TX FIFO
module tx_resp_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ALU_WIDTH  = 2 * DATA_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST_n,
    input  logic [DATA_WIDTH-1:0] RF_DATA,
    input  logic                  RF_VALID,
    input  logic [ALU_WIDTH-1:0]  ALU_DATA,
    input  logic                  ALU_VALID,
    input  logic                  FIFO_FULL,
    output logic [DATA_WIDTH-1:0] WR_DATA,
    output logic                  WR_INC,
    output logic                  RF_PEND,
    output logic                  ALU_PEND,
    output logic                  OVERRUN,
    output logic                  BUSY
);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        SEND_RF     = 2'd1,
        SEND_ALU_LO = 2'd2,
        SEND_ALU_HI = 2'd3
    } state_e;

    localparam logic GRANT_RF  = 1'b0;
    localparam logic GRANT_ALU = 1'b1;

    state_e                  state_q, state_d;
    logic                    rf_pend_q, rf_pend_d;
    logic                    alu_pend_q, alu_pend_d;
    logic [DATA_WIDTH-1:0]   rf_hold_q, rf_hold_d;
    logic [ALU_WIDTH-1:0]    alu_hold_q, alu_hold_d;
    logic                    last_grant_q, last_grant_d;
    logic                    overrun_q, overrun_d;

    logic rf_clear, alu_clear;
    logic rf_accept, alu_accept;
    logic rf_drop, alu_drop;

    // A holding register frees up on the same edge its final byte is written.
    assign rf_clear   = (state_q == SEND_RF)     && !FIFO_FULL;
    assign alu_clear  = (state_q == SEND_ALU_HI) && !FIFO_FULL;
    assign rf_accept  = RF_VALID  && (!rf_pend_q  || rf_clear);
    assign alu_accept = ALU_VALID && (!alu_pend_q || alu_clear);
    assign rf_drop    = RF_VALID  && rf_pend_q  && !rf_clear;
    assign alu_drop   = ALU_VALID && alu_pend_q && !alu_clear;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            rf_pend_q    <= 1'b0;
            alu_pend_q   <= 1'b0;
            rf_hold_q    <= '0;
            alu_hold_q   <= '0;
            last_grant_q <= GRANT_ALU;
            overrun_q    <= 1'b0;
        end else begin
            rf_pend_q    <= rf_pend_d;
            alu_pend_q   <= alu_pend_d;
            rf_hold_q    <= rf_hold_d;
            alu_hold_q   <= alu_hold_d;
            last_grant_q <= last_grant_d;
            overrun_q    <= overrun_d;
        end
    end

    always_comb begin
        rf_pend_d    = rf_pend_q;
        alu_pend_d   = alu_pend_q;
        rf_hold_d    = rf_hold_q;
        alu_hold_d   = alu_hold_q;
        last_grant_d = last_grant_q;
        overrun_d    = rf_drop || alu_drop;

        if (rf_clear) begin
            rf_pend_d    = 1'b0;
            last_grant_d = GRANT_RF;
        end
        if (alu_clear) begin
            alu_pend_d   = 1'b0;
            last_grant_d = GRANT_ALU;
        end
        if (rf_accept) begin
            rf_pend_d = 1'b1;
            rf_hold_d = RF_DATA;
        end
        if (alu_accept) begin
            alu_pend_d = 1'b1;
            alu_hold_d = ALU_DATA;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (rf_pend_q && (!alu_pend_q || last_grant_q == GRANT_ALU)) begin
                    state_d = SEND_RF;
                end else if (alu_pend_q) begin
                    state_d = SEND_ALU_LO;
                end
            end
            SEND_RF:     if (!FIFO_FULL) state_d = IDLE;
            SEND_ALU_LO: if (!FIFO_FULL) state_d = SEND_ALU_HI;
            SEND_ALU_HI: if (!FIFO_FULL) state_d = IDLE;
            default:     state_d = IDLE;
        endcase
    end

    always_comb begin
        WR_INC  = 1'b0;
        WR_DATA = '0;
        case (state_q)
            SEND_RF: begin
                WR_INC  = !FIFO_FULL;
                WR_DATA = rf_hold_q;
            end
            SEND_ALU_LO: begin
                WR_INC  = !FIFO_FULL;
                WR_DATA = alu_hold_q[DATA_WIDTH-1:0];
            end
            SEND_ALU_HI: begin
                WR_INC  = !FIFO_FULL;
                WR_DATA = alu_hold_q[ALU_WIDTH-1:DATA_WIDTH];
            end
            default: begin
                WR_INC  = 1'b0;
                WR_DATA = '0;
            end
        endcase
    end

    assign RF_PEND  = rf_pend_q;
    assign ALU_PEND = alu_pend_q;
    assign OVERRUN  = overrun_q;
    assign BUSY     = (state_q != IDLE) || rf_pend_q || alu_pend_q;

endmodule

// File: tb/tb_tx_resp_arbiter.sv
// tb/tb_tx_resp_arbiter.sv - directed vector bench for tx_resp_arbiter
module tb_tx_resp_arbiter;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rf_data;
    logic        rf_valid;
    logic [15:0] alu_data;
    logic        alu_valid;
    logic        fifo_full;
    logic [7:0]  wr_data;
    logic        wr_inc;
    logic        rf_pend;
    logic        alu_pend;
    logic        overrun;
    logic        busy;

    int n_vec  = 0;
    int n_miss = 0;

    tx_resp_arbiter #(.DATA_WIDTH(8), .ALU_WIDTH(16)) dut (
        .CLK       (clk),
        .RST_n     (rst_n),
        .RF_DATA   (rf_data),
        .RF_VALID  (rf_valid),
        .ALU_DATA  (alu_data),
        .ALU_VALID (alu_valid),
        .FIFO_FULL (fifo_full),
        .WR_DATA   (wr_data),
        .WR_INC    (wr_inc),
        .RF_PEND   (rf_pend),
        .ALU_PEND  (alu_pend),
        .OVERRUN   (overrun),
        .BUSY      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rv;
        logic [7:0]  rd;
        logic        av;
        logic [15:0] ad;
        logic        ff;
        logic        inc;
        logic [7:0]  wd;
        logic        rp;
        logic        ap;
        logic        ov;
        logic        bsy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rv, logic [7:0] rd, logic av, logic [15:0] ad, logic ff,
                                logic inc, logic [7:0] wd, logic rp, logic ap, logic ov, logic bsy);
        vec_t v;
        v.rv = rv; v.rd = rd; v.av = av; v.ad = ad; v.ff = ff;
        v.inc = inc; v.wd = wd; v.rp = rp; v.ap = ap; v.ov = ov; v.bsy = bsy;
        return v;
    endfunction

    task automatic cmp1(input string nm, input string f, input logic [7:0] got, input logic [7:0] exp);
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s.%s: got %h expected %h", nm, f, got, exp);
        end
    endtask

    task automatic check(input string nm, input logic e_inc, input logic [7:0] e_wd,
                         input logic e_rp, input logic e_ap, input logic e_ov, input logic e_bsy);
        n_vec++;
        cmp1(nm, "WR_INC",   {7'd0, wr_inc},   {7'd0, e_inc});
        cmp1(nm, "WR_DATA",  wr_data,          e_wd);
        cmp1(nm, "RF_PEND",  {7'd0, rf_pend},  {7'd0, e_rp});
        cmp1(nm, "ALU_PEND", {7'd0, alu_pend}, {7'd0, e_ap});
        cmp1(nm, "OVERRUN",  {7'd0, overrun},  {7'd0, e_ov});
        cmp1(nm, "BUSY",     {7'd0, busy},     {7'd0, e_bsy});
    endtask

    task automatic drive(input logic rv, input logic [7:0] rd, input logic av,
                         input logic [15:0] ad, input logic ff);
        rf_valid = rv; rf_data = rd; alu_valid = av; alu_data = ad; fifo_full = ff;
    endtask

    initial begin
        //                rv rd     av ad        ff  inc wd     rp ap ov bsy
        // single RF byte A5
        tbl.push_back(mk(1, 8'hA5, 0, 16'h0000, 0,  0, 8'h00, 0, 0, 0, 0));
        tbl.push_back(mk(0, 8'h00, 0, 16'h0000, 0,  0, 8'h00, 1, 0, 0, 1));
        tbl.push_back(mk(0, 8'h00, 0, 16'h0000, 0,  1, 8'hA5, 1, 0, 0, 1));
        tbl.push_back(mk(0, 8'h00, 0, 16'h0000, 0,  0, 8'h00, 0, 0, 0, 0));
        // ALU word 1234, low byte first
        tbl.push_back(mk(0, 8'h00, 1, 16'h1234, 0,  0, 8'h00, 0, 0, 0, 0));
        tbl.push_back(mk(0, 8'h00, 0, 16'h0000, 0,  0, 8'h00, 0, 1, 0, 1));
        tbl.push_back(mk(0, 8'h00, 0, 16'h0000, 0,  1, 8'h34, 0, 1, 0, 1));
        tbl.push_back(mk(0, 8'h00, 0, 16'h0000, 0,  1, 8'h12, 0, 1, 0, 1));
        // simultaneous RF 11 / ALU BEEF with last grant ALU: RF first
        tbl.push_back(mk(1, 8'h11, 1, 16'hBEEF, 0,  0, 8'h00, 0, 0, 0, 0));
        tbl.push_back(mk(0, 8'h00, 0, 16'h0000, 0,  0, 8'h00, 1, 1, 0, 1));
        tbl.push_back(mk(0, 8'h00, 0, 16'h0000, 0,  1, 8'h11, 1, 1, 0, 1));
        tbl.push_back(mk(0, 8'h00, 0, 16'h0000, 0,  0, 8'h00, 0, 1, 0, 1));
        tbl.push_back(mk(0, 8'h00, 0, 16'h0000, 0,  1, 8'hEF, 0, 1, 0, 1));
        tbl.push_back(mk(0, 8'h00, 0, 16'h0000, 0,  1, 8'hBE, 0, 1, 0, 1));
        // RF 22 alone, then simultaneous RF 33 / ALU 5678 with last grant RF: ALU first
        tbl.push_back(mk(1, 8'h22, 0, 16'h0000, 0,  0, 8'h00, 0, 0, 0, 0));
        tbl.push_back(mk(0, 8'h00, 0, 16'h0000, 0,  0, 8'h00, 1, 0, 0, 1));
        tbl.push_back(mk(0, 8'h00, 0, 16'h0000, 0,  1, 8'h22, 1, 0, 0, 1));
        tbl.push_back(mk(1, 8'h33, 1, 16'h5678, 0,  0, 8'h00, 0, 0, 0, 0));
        tbl.push_back(mk(0, 8'h00, 0, 16'h0000, 0,  0, 8'h00, 1, 1, 0, 1));
        tbl.push_back(mk(0, 8'h00, 0, 16'h0000, 0,  1, 8'h78, 1, 1, 0, 1));
        tbl.push_back(mk(0, 8'h00, 0, 16'h0000, 0,  1, 8'h56, 1, 1, 0, 1));
        tbl.push_back(mk(0, 8'h00, 0, 16'h0000, 0,  0, 8'h00, 1, 0, 0, 1));
        tbl.push_back(mk(0, 8'h00, 0, 16'h0000, 0,  1, 8'h33, 1, 0, 0, 1));
        // CAFE with FIFO full for 5 cycles in SEND_ALU_HI
        tbl.push_back(mk(0, 8'h00, 1, 16'hCAFE, 0,  0, 8'h00, 0, 0, 0, 0));
        tbl.push_back(mk(0, 8'h00, 0, 16'h0000, 0,  0, 8'h00, 0, 1, 0, 1));
        tbl.push_back(mk(0, 8'h00, 0, 16'h0000, 0,  1, 8'hFE, 0, 1, 0, 1));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(0, 8'h00, 0, 16'h0000, 1,  0, 8'hCA, 0, 1, 0, 1));
        tbl.push_back(mk(0, 8'h00, 0, 16'h0000, 0,  1, 8'hCA, 0, 1, 0, 1));
        // two RF strobes while full: second dropped, one OVERRUN pulse
        tbl.push_back(mk(1, 8'h01, 0, 16'h0000, 1,  0, 8'h00, 0, 0, 0, 0));
        tbl.push_back(mk(1, 8'h02, 0, 16'h0000, 1,  0, 8'h00, 1, 0, 0, 1));
        tbl.push_back(mk(0, 8'h00, 0, 16'h0000, 1,  0, 8'h01, 1, 0, 1, 1));
        tbl.push_back(mk(0, 8'h00, 0, 16'h0000, 1,  0, 8'h01, 1, 0, 0, 1));
        tbl.push_back(mk(0, 8'h00, 0, 16'h0000, 0,  1, 8'h01, 1, 0, 0, 1));
        // new RF strobe on the edge the pending byte is written: captured, no overrun
        tbl.push_back(mk(1, 8'h44, 0, 16'h0000, 0,  0, 8'h00, 0, 0, 0, 0));
        tbl.push_back(mk(0, 8'h00, 0, 16'h0000, 0,  0, 8'h00, 1, 0, 0, 1));
        tbl.push_back(mk(1, 8'h55, 0, 16'h0000, 0,  1, 8'h44, 1, 0, 0, 1));
        tbl.push_back(mk(0, 8'h00, 0, 16'h0000, 0,  0, 8'h00, 1, 0, 0, 1));
        tbl.push_back(mk(0, 8'h00, 0, 16'h0000, 0,  1, 8'h55, 1, 0, 0, 1));
        tbl.push_back(mk(0, 8'h00, 0, 16'h0000, 0,  0, 8'h00, 0, 0, 0, 0));

        rst_n = 1'b0;
        drive(0, 8'h00, 0, 16'h0000, 0);
        repeat (2) @(negedge clk);
        #1 check("reset", 0, 8'h00, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            if (i != 0) @(negedge clk);
            drive(tbl[i].rv, tbl[i].rd, tbl[i].av, tbl[i].ad, tbl[i].ff);
            #1 check($sformatf("row%0d", i), tbl[i].inc, tbl[i].wd, tbl[i].rp,
                     tbl[i].ap, tbl[i].ov, tbl[i].bsy);
        end

        // reset asserted in SEND_ALU_HI: last grant is RF, so ALU 9ABC goes first
        @(negedge clk);
        drive(1, 8'h66, 1, 16'h9ABC, 0);
        #1 check("rst_seq0", 0, 8'h00, 0, 0, 0, 0);
        @(negedge clk);
        drive(0, 8'h00, 0, 16'h0000, 0);
        #1 check("rst_seq1", 0, 8'h00, 1, 1, 0, 1);
        @(negedge clk);
        #1 check("rst_seq_lo", 1, 8'hBC, 1, 1, 0, 1);
        @(negedge clk);
        #1 check("rst_seq_hi", 1, 8'h9A, 1, 1, 0, 1);
        #1 rst_n = 1'b0;
        #1 check("rst_mid_word", 0, 8'h00, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1 check($sformatf("post_rst%0d", i), 0, 8'h00, 0, 0, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
